sip_out_fifo_core: RTL and testbench

Single-clock, 8-entry output-serializer FIFO for the I/O datapath. Each entry holds ten 8-bit lanes (D0..D9). In ARRAY_MODE_8_X_4 every 8-bit lane is unloaded as two 4-bit nibbles, low nibble first. In ARRAY_MODE_4_X_4 one 4-bit nibble is unloaded per entry. Status flags drive the upstream writer and the downstream PHY reader.

---
 rtl/sip_out_fifo_core_if.sv | 22 ++
 rtl/sip_out_fifo_core.sv | 129 ++++++++++++
 tb/tb_sip_out_fifo_core.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sip_out_fifo_core_if.sv
// Bus bundle for sip_out_fifo_core: write/read requests, ten write lanes,
// registered read lanes and status flags.
interface sip_out_fifo_core_if;
    logic       WREN;
    logic       RDEN;
    logic [7:0] D0, D1, D2, D3, D4, D5, D6, D7, D8, D9;
    logic [3:0] Q0, Q1, Q2, Q3, Q4, Q7, Q8, Q9;
    logic [7:0] Q5, Q6;
    logic       EMPTY, ALMOSTEMPTY, FULL, ALMOSTFULL;

    modport master (
        output WREN, RDEN, D0, D1, D2, D3, D4, D5, D6, D7, D8, D9,
        input  Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8, Q9,
        input  EMPTY, ALMOSTEMPTY, FULL, ALMOSTFULL
    );

    modport slave (
        input  WREN, RDEN, D0, D1, D2, D3, D4, D5, D6, D7, D8, D9,
        output Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8, Q9,
        output EMPTY, ALMOSTEMPTY, FULL, ALMOSTFULL
    );
endinterface

// File: rtl/sip_out_fifo_core.sv
// 8-entry x 80-bit output-serializer FIFO; each entry is unloaded either as one
// nibble per lane (4_X_4) or as low then high nibble over two reads (8_X_4).
module sip_out_fifo_core #(
    parameter int unsigned ALMOST_EMPTY_VALUE = 1,
    parameter int unsigned ALMOST_FULL_VALUE  = 1,
    parameter string       ARRAY_MODE         = "ARRAY_MODE_8_X_4",
    parameter string       OUTPUT_DISABLE     = "FALSE"
) (
    input logic               CLK,
    input logic               RESETB,
    sip_out_fifo_core_if.slave bus
);

    if (ALMOST_EMPTY_VALUE < 1 || ALMOST_EMPTY_VALUE > 2) begin : gen_bad_ae
        $fatal(1, "sip_out_fifo_core: ALMOST_EMPTY_VALUE must be 1..2");
    end
    if (ALMOST_FULL_VALUE < 1 || ALMOST_FULL_VALUE > 2) begin : gen_bad_af
        $fatal(1, "sip_out_fifo_core: ALMOST_FULL_VALUE must be 1..2");
    end
    if (ARRAY_MODE != "ARRAY_MODE_8_X_4" && ARRAY_MODE != "ARRAY_MODE_4_X_4") begin : gen_bad_mode
        $fatal(1, "sip_out_fifo_core: illegal ARRAY_MODE");
    end
    if (OUTPUT_DISABLE != "TRUE" && OUTPUT_DISABLE != "FALSE") begin : gen_bad_od
        $fatal(1, "sip_out_fifo_core: illegal OUTPUT_DISABLE");
    end

    localparam bit         Mode8x4  = (ARRAY_MODE == "ARRAY_MODE_8_X_4");
    localparam bit         OutEn    = (OUTPUT_DISABLE == "FALSE");
    localparam logic [3:0] AeThresh = 4'(ALMOST_EMPTY_VALUE);
    localparam logic [3:0] AfThresh = 4'(ALMOST_FULL_VALUE);

    // Narrow output j maps to lane 0-4 or 7-9.
    function automatic int narrow_lane(input int j);
        return (j < 5) ? j : j + 2;
    endfunction

    logic [79:0] mem_q [8];
    logic [2:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]  count_q, count_d;
    logic        phase_q, phase_d;
    logic [3:0]  qn_q [8];
    logic [3:0]  qn_d [8];
    logic [7:0]  qw_q [2];
    logic [7:0]  qw_d [2];

    logic [79:0] wr_data, rd_entry;
    logic        empty, full, wr_ok, rd_ok, pop;
    logic [7:0]  lane;

    assign empty    = (count_q == 4'd0);
    assign full     = (count_q == 4'd8);
    assign wr_ok    = bus.WREN && !full;
    assign rd_ok    = bus.RDEN && !empty;
    assign pop      = rd_ok && (!Mode8x4 || phase_q);
    assign wr_data  = {bus.D9, bus.D8, bus.D7, bus.D6, bus.D5,
                       bus.D4, bus.D3, bus.D2, bus.D1, bus.D0};
    assign rd_entry = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ok ? wr_ptr_q + 3'd1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 3'd1 : rd_ptr_q;
        phase_d  = (Mode8x4 && rd_ok) ? !phase_q : phase_q;
        unique case ({wr_ok, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        qn_d = qn_q;
        qw_d = qw_q;
        lane = '0;
        if (rd_ok) begin
            for (int j = 0; j < 8; j++) begin
                lane    = rd_entry[narrow_lane(j)*8 +: 8];
                qn_d[j] = (Mode8x4 && phase_q) ? lane[7:4] : lane[3:0];
            end
            for (int w = 0; w < 2; w++) begin
                lane = rd_entry[(5+w)*8 +: 8];
                if (Mode8x4) begin
                    qw_d[w] = {4'b0, phase_q ? lane[7:4] : lane[3:0]};
                end else begin
                    qw_d[w] = lane;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            phase_q  <= 1'b0;
            for (int j = 0; j < 8; j++) qn_q[j] <= '0;
            for (int w = 0; w < 2; w++) qw_q[w] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            phase_q  <= phase_d;
            qn_q     <= qn_d;
            qw_q     <= qw_d;
        end
    end

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge CLK) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end

    assign bus.Q0 = OutEn ? qn_q[0] : '0;
    assign bus.Q1 = OutEn ? qn_q[1] : '0;
    assign bus.Q2 = OutEn ? qn_q[2] : '0;
    assign bus.Q3 = OutEn ? qn_q[3] : '0;
    assign bus.Q4 = OutEn ? qn_q[4] : '0;
    assign bus.Q7 = OutEn ? qn_q[5] : '0;
    assign bus.Q8 = OutEn ? qn_q[6] : '0;
    assign bus.Q9 = OutEn ? qn_q[7] : '0;
    assign bus.Q5 = OutEn ? qw_q[0] : '0;
    assign bus.Q6 = OutEn ? qw_q[1] : '0;

    assign bus.EMPTY       = empty;
    assign bus.FULL        = full;
    assign bus.ALMOSTEMPTY = (count_q <= AeThresh);
    assign bus.ALMOSTFULL  = ((4'd8 - count_q) <= AfThresh);

endmodule

// File: tb/tb_sip_out_fifo_core.sv
// Directed bench for sip_out_fifo_core: one 8_X_4 instance, one 4_X_4 instance
// and a 4_X_4 instance with outputs disabled that mirrors the 4_X_4 stimulus.
module tb_sip_out_fifo_core;

    logic clk = 1'b0;
    logic resetb;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    sip_out_fifo_core_if if8 ();
    sip_out_fifo_core_if if4 ();
    sip_out_fifo_core_if ifd ();

    sip_out_fifo_core #(.ARRAY_MODE("ARRAY_MODE_8_X_4")) u_dut8 (
        .CLK(clk), .RESETB(resetb), .bus(if8)
    );
    sip_out_fifo_core #(.ARRAY_MODE("ARRAY_MODE_4_X_4")) u_dut4 (
        .CLK(clk), .RESETB(resetb), .bus(if4)
    );
    sip_out_fifo_core #(.ARRAY_MODE("ARRAY_MODE_4_X_4"), .OUTPUT_DISABLE("TRUE")) u_dutd (
        .CLK(clk), .RESETB(resetb), .bus(ifd)
    );

    always_comb begin
        ifd.WREN = if4.WREN; ifd.RDEN = if4.RDEN;
        ifd.D0 = if4.D0; ifd.D1 = if4.D1; ifd.D2 = if4.D2; ifd.D3 = if4.D3; ifd.D4 = if4.D4;
        ifd.D5 = if4.D5; ifd.D6 = if4.D6; ifd.D7 = if4.D7; ifd.D8 = if4.D8; ifd.D9 = if4.D9;
    end

    // {EMPTY, ALMOSTEMPTY, FULL, ALMOSTFULL}
    logic [3:0] fl8, fl4;
    assign fl8 = {if8.EMPTY, if8.ALMOSTEMPTY, if8.FULL, if8.ALMOSTFULL};
    assign fl4 = {if4.EMPTY, if4.ALMOSTEMPTY, if4.FULL, if4.ALMOSTFULL};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        if8.WREN = 0; if8.RDEN = 0;
        if8.D0 = 0; if8.D1 = 0; if8.D2 = 0; if8.D3 = 0; if8.D4 = 0;
        if8.D5 = 0; if8.D6 = 0; if8.D7 = 0; if8.D8 = 0; if8.D9 = 0;
        if4.WREN = 0; if4.RDEN = 0;
        if4.D0 = 0; if4.D1 = 0; if4.D2 = 0; if4.D3 = 0; if4.D4 = 0;
        if4.D5 = 0; if4.D6 = 0; if4.D7 = 0; if4.D8 = 0; if4.D9 = 0;
    endtask

    initial begin
        clear_inputs();
        resetb = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check_eq("rst flags8", 32'(fl8), 32'b1100);
        check_eq("rst flags4", 32'(fl4), 32'b1100);
        check_eq("rst q0_8", 32'(if8.Q0), 0);
        check_eq("rst q5_8", 32'(if8.Q5), 0);
        check_eq("rst q9_4", 32'(if4.Q9), 0);
        resetb = 1'b1;
        @(negedge clk);

        // 4_X_4 single write then read
        if4.D0 = 8'hA5; if4.D5 = 8'h3C; if4.D9 = 8'h7E; if4.WREN = 1;
        @(negedge clk);
        if4.WREN = 0;
        check_eq("4x4 not empty", 32'(if4.EMPTY), 0);
        if4.RDEN = 1;
        @(negedge clk);
        if4.RDEN = 0;
        check_eq("4x4 q0", 32'(if4.Q0), 'h5);
        check_eq("4x4 q5", 32'(if4.Q5), 'h3C);
        check_eq("4x4 q9", 32'(if4.Q9), 'hE);
        check_eq("4x4 empty", 32'(if4.EMPTY), 1);
        check_eq("dis q0", 32'(ifd.Q0), 0);
        check_eq("dis q5", 32'(ifd.Q5), 0);
        check_eq("dis empty", 32'(ifd.EMPTY), 1);

        // 8_X_4 single write then two reads
        if8.D0 = 8'hA5; if8.D6 = 8'hC3; if8.WREN = 1;
        @(negedge clk);
        if8.WREN = 0; if8.RDEN = 1;
        @(negedge clk);
        check_eq("8x4 ph0 q0", 32'(if8.Q0), 'h5);
        check_eq("8x4 ph0 q6", 32'(if8.Q6), 'h03);
        check_eq("8x4 ph0 empty", 32'(if8.EMPTY), 0);
        @(negedge clk);
        if8.RDEN = 0;
        check_eq("8x4 ph1 q0", 32'(if8.Q0), 'hA);
        check_eq("8x4 ph1 q6", 32'(if8.Q6), 'h0C);
        check_eq("8x4 ph1 empty", 32'(if8.EMPTY), 1);

        // 8_X_4 fill to 8, overflow write, ordered drain
        for (int i = 0; i < 8; i++) begin
            if8.D0 = {4'(i + 2), 4'(i)}; if8.D9 = 8'(8'h90 + i); if8.WREN = 1;
            @(negedge clk);
            check_eq($sformatf("fill flags c%0d", i + 1), 32'(fl8),
                     {28'd0, 1'b0, 1'(i + 1 <= 1), 1'(i + 1 == 8), 1'(7 - i <= 1)});
        end
        if8.D0 = 8'hFF;
        @(negedge clk);
        if8.WREN = 0;
        check_eq("overflow full", 32'(fl8), 32'b0011);
        for (int i = 0; i < 8; i++) begin
            if8.RDEN = 1;
            @(negedge clk);
            check_eq($sformatf("drain lo q0 e%0d", i), 32'(if8.Q0), 32'(i));
            check_eq($sformatf("drain lo q9 e%0d", i), 32'(if8.Q9), 32'(i));
            @(negedge clk);
            check_eq($sformatf("drain hi q0 e%0d", i), 32'(if8.Q0), 32'(i + 2));
            check_eq($sformatf("drain hi q9 e%0d", i), 32'(if8.Q9), 'h9);
        end
        check_eq("drained flags", 32'(fl8), 32'b1100);
        @(negedge clk);
        if8.RDEN = 0;
        check_eq("empty read hold", 32'(if8.Q0), 'h9);

        // 4_X_4 full with simultaneous write+read
        for (int i = 0; i < 8; i++) begin
            if4.D0 = 8'(8'h50 + i); if4.WREN = 1;
            @(negedge clk);
        end
        if4.WREN = 0;
        check_eq("4x4 full", 32'(fl4), 32'b0011);
        if4.D0 = 8'hEE; if4.WREN = 1; if4.RDEN = 1;
        @(negedge clk);
        if4.WREN = 0; if4.RDEN = 0;
        check_eq("full both q0", 32'(if4.Q0), 'h0);
        check_eq("full both flags", 32'(fl4), 32'b0001);
        for (int i = 1; i < 8; i++) begin
            if4.RDEN = 1;
            @(negedge clk);
            check_eq($sformatf("full drain e%0d", i), 32'(if4.Q0), 32'(i));
        end
        if4.RDEN = 0;
        check_eq("full drain empty", 32'(fl4), 32'b1100);

        // 4_X_4 empty with simultaneous write+read
        if4.D0 = 8'h3B; if4.WREN = 1; if4.RDEN = 1;
        @(negedge clk);
        if4.WREN = 0; if4.RDEN = 0;
        check_eq("empty both hold", 32'(if4.Q0), 'h7);
        check_eq("empty both flags", 32'(fl4), 32'b0100);
        if4.RDEN = 1;
        @(negedge clk);
        if4.RDEN = 0;
        check_eq("empty both data", 32'(if4.Q0), 'hB);
        check_eq("empty both drained", 32'(if4.EMPTY), 1);

        // Asynchronous reset mid-stream at count 5
        for (int i = 0; i < 5; i++) begin
            if8.D0 = 8'(8'h60 + i); if8.WREN = 1;
            @(negedge clk);
        end
        if8.WREN = 0;
        check_eq("pre-reset flags", 32'(fl8), 32'b0000);
        #2 resetb = 1'b0;
        #1;
        check_eq("async rst flags", 32'(fl8), 32'b1100);
        check_eq("async rst q0", 32'(if8.Q0), 0);
        @(negedge clk);
        resetb = 1'b1;
        if8.RDEN = 1;
        @(negedge clk);
        if8.RDEN = 0;
        check_eq("post-rst read q0", 32'(if8.Q0), 0);
        check_eq("post-rst empty", 32'(if8.EMPTY), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
